// File: rtl/note_pkg.sv
// Shared constants for the note tone generator: note codes, half-period table, FSM states.
package note_pkg;

   localparam int unsigned PERIOD_W   = 15;
   localparam int unsigned NOTE_W     = 4;
   localparam int unsigned OCT_W      = 2;
   localparam int unsigned NUM_NOTES  = 13;
   localparam int unsigned TBL_CLK_HZ = 12000000;

   localparam logic [NOTE_W-1:0] NOTE_C      = 4'd0;
   localparam logic [NOTE_W-1:0] NOTE_CS     = 4'd1;
   localparam logic [NOTE_W-1:0] NOTE_D      = 4'd2;
   localparam logic [NOTE_W-1:0] NOTE_DS     = 4'd3;
   localparam logic [NOTE_W-1:0] NOTE_E      = 4'd4;
   localparam logic [NOTE_W-1:0] NOTE_F      = 4'd5;
   localparam logic [NOTE_W-1:0] NOTE_FS     = 4'd6;
   localparam logic [NOTE_W-1:0] NOTE_G      = 4'd7;
   localparam logic [NOTE_W-1:0] NOTE_GS     = 4'd8;
   localparam logic [NOTE_W-1:0] NOTE_A      = 4'd9;
   localparam logic [NOTE_W-1:0] NOTE_AS     = 4'd10;
   localparam logic [NOTE_W-1:0] NOTE_B      = 4'd11;
   localparam logic [NOTE_W-1:0] NOTE_C_HI   = 4'd12;
   localparam logic [NOTE_W-1:0] NOTE_SILENT = 4'hF;

   // Half-period in clock cycles at TBL_CLK_HZ, octave 0, indexed by semitone.
   localparam logic [PERIOD_W-1:0] HALF_PERIOD_TBL [NUM_NOTES] = '{
      15'd22933, 15'd21647, 15'd20432, 15'd19285, 15'd18202, 15'd17181, 15'd16217,
      15'd15306, 15'd14447, 15'd13636, 15'd12871, 15'd12149, 15'd11467
   };

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PLAY = 1'b1
   } state_t;

endpackage

// File: rtl/note_period_rom.sv
// Combinational note/octave to half-period lookup. Codes above NOTE_C_HI return 0.
module note_period_rom
   import note_pkg::*;
#(
   parameter int unsigned CLK_HZ = TBL_CLK_HZ
) (
   input  logic [NOTE_W-1:0]   i_note,
   input  logic [OCT_W-1:0]    i_octave,
   output logic [PERIOD_W-1:0] o_period
);

   logic [PERIOD_W-1:0] w_p0;

   // Table select; each entry is rescaled by a constant so it folds away at elaboration.
   always_comb begin
      w_p0 = '0;
      for (int i = 0; i < int'(NUM_NOTES); i++) begin
         if (i_note == NOTE_W'(i)) begin
            w_p0 = PERIOD_W'((64'(HALF_PERIOD_TBL[i]) * 64'(CLK_HZ)) / 64'(TBL_CLK_HZ));
         end
      end
   end

   assign o_period = w_p0 >> i_octave;

endmodule

// File: rtl/note_tone_gen.sv
// Square-wave note generator; note/octave changes only take effect at full-period boundaries.
module note_tone_gen
   import note_pkg::*;
#(
   parameter int unsigned CLK_HZ = 12000000
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       en,
   input  logic [3:0] note_in,
   input  logic [1:0] octave,
   output logic       tone_out,
   output logic       active,
   output logic       period_start
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [PERIOD_W-1:0] r_cnt;
   logic [PERIOD_W-1:0] w_cnt_nxt;
   logic [NOTE_W-1:0]   r_note;
   logic [NOTE_W-1:0]   w_note_nxt;
   logic [OCT_W-1:0]    r_oct;
   logic [OCT_W-1:0]    w_oct_nxt;
   logic                r_tone;
   logic                w_tone_nxt;
   logic                r_active;
   logic                w_active_nxt;
   logic                r_pstart;
   logic                w_pstart_nxt;

   logic                w_req_valid;
   logic                w_use_latched;
   logic [NOTE_W-1:0]   w_rom_note;
   logic [OCT_W-1:0]    w_rom_oct;
   logic [PERIOD_W-1:0] w_period;
   logic [PERIOD_W-1:0] w_reload;

   assign w_req_valid   = en && (note_in <= NOTE_C_HI);
   // The mid-period (high to low) reload always uses the note that started the period.
   assign w_use_latched = (r_state == ST_PLAY) && r_tone;
   assign w_rom_note    = w_use_latched ? r_note : note_in;
   assign w_rom_oct     = w_use_latched ? r_oct  : octave;
   assign w_reload      = PERIOD_W'(w_period - PERIOD_W'(1));

   note_period_rom #(
      .CLK_HZ   (CLK_HZ)
   ) u_rom (
      .i_note   (w_rom_note),
      .i_octave (w_rom_oct),
      .o_period (w_period)
   );

   // State, counter and output registers.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_note   <= NOTE_SILENT;
         r_oct    <= '0;
         r_tone   <= 1'b0;
         r_active <= 1'b0;
         r_pstart <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_note   <= w_note_nxt;
         r_oct    <= w_oct_nxt;
         r_tone   <= w_tone_nxt;
         r_active <= w_active_nxt;
         r_pstart <= w_pstart_nxt;
      end
   end

   // Next-state, counter and output decode.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_note_nxt   = r_note;
      w_oct_nxt    = r_oct;
      w_tone_nxt   = r_tone;
      w_pstart_nxt = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_cnt_nxt  = '0;
            w_tone_nxt = 1'b0;
            if (w_req_valid) begin
               w_note_nxt   = note_in;
               w_oct_nxt    = octave;
               w_tone_nxt   = 1'b1;
               w_cnt_nxt    = w_reload;
               w_pstart_nxt = 1'b1;
               w_state_nxt  = ST_PLAY;
            end
         end
         ST_PLAY: begin
            if (r_cnt != '0) begin
               w_cnt_nxt = PERIOD_W'(r_cnt - PERIOD_W'(1));
            end else if (r_tone) begin
               w_tone_nxt = 1'b0;
               w_cnt_nxt  = w_reload;
            end else if (w_req_valid) begin
               w_note_nxt   = note_in;
               w_oct_nxt    = octave;
               w_tone_nxt   = 1'b1;
               w_cnt_nxt    = w_reload;
               w_pstart_nxt = 1'b1;
            end else begin
               w_cnt_nxt   = '0;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_tone_nxt  = 1'b0;
         end
      endcase

      w_active_nxt = (w_state_nxt == ST_PLAY);
   end

   assign tone_out     = r_tone;
   assign active       = r_active;
   assign period_start = r_pstart;

endmodule

// File: tb/tb_note_tone_gen.sv
// Self-checking bench for note_tone_gen: measures half-period lengths against a table model.
module tb_note_tone_gen;

   logic       clk;
   logic       n_rst;
   logic       en;
   logic [3:0] note_in;
   logic [1:0] octave;
   logic       tone_out;
   logic       active;
   logic       period_start;

   int checks = 0;
   int errors = 0;

   int half_tbl [13] = '{22933, 21647, 20432, 19285, 18202, 17181, 16217,
                         15306, 14447, 13636, 12871, 12149, 11467};

   note_tone_gen #(
      .CLK_HZ       (12000000)
   ) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .en           (en),
      .note_in      (note_in),
      .octave       (octave),
      .tone_out     (tone_out),
      .active       (active),
      .period_start (period_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int exp_half(input int n, input int o);
      return half_tbl[n] >> o;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starting on the first high sample, count high cycles, low cycles and period_start pulses.
   // At high cycle act_cyc the inputs are replaced to model a mid-period sequencer change.
   task automatic measure_period(input int act_cyc, input logic act_en, input logic [3:0] act_note,
                                 input logic [1:0] act_oct, input int limit,
                                 output int hi, output int lo, output int ps);
      hi = 0;
      lo = 0;
      ps = 0;
      while (tone_out === 1'b1 && hi < limit) begin
         hi++;
         if (period_start === 1'b1) ps++;
         if (hi == act_cyc) begin
            en      = act_en;
            note_in = act_note;
            octave  = act_oct;
         end
         tick();
      end
      while (tone_out === 1'b0 && active === 1'b1 && lo < limit) begin
         lo++;
         if (period_start === 1'b1) ps++;
         tick();
      end
   endtask

   task automatic test_reset();
      n_rst = 1'b0; en = 1'b0; note_in = 4'hF; octave = 2'd0;
      repeat (3) tick();
      checks++; if (tone_out !== 1'b0) begin errors++; $display("FAIL rst_tone got %0b expected 0", tone_out); end
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL rst_active got %0b expected 0", active); end
      checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL rst_pstart got %0b expected 0", period_start); end
      n_rst = 1'b1;
      repeat (2) tick();
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL rst_idle_active got %0b expected 0", active); end
   endtask

   task automatic test_basic();
      int exp, hi, lo, ps;
      en = 1'b1; note_in = 4'd9; octave = 2'd0;
      exp = exp_half(9, 0);
      checks++; if (tone_out !== 1'b0) begin errors++; $display("FAIL basic_pre_tone got %0b expected 0", tone_out); end
      tick();
      checks++; if (tone_out !== 1'b1) begin errors++; $display("FAIL basic_rise got %0b expected 1", tone_out); end
      checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL basic_pstart got %0b expected 1", period_start); end
      checks++; if (active !== 1'b1) begin errors++; $display("FAIL basic_active got %0b expected 1", active); end
      measure_period(exp / 2, 1'b0, 4'd9, 2'd0, exp + 4, hi, lo, ps);
      checks++; if (hi !== exp) begin errors++; $display("FAIL basic_high got %0d expected %0d", hi, exp); end
      checks++; if (lo !== exp) begin errors++; $display("FAIL basic_low got %0d expected %0d", lo, exp); end
      checks++; if (ps !== 1) begin errors++; $display("FAIL basic_pstart_count got %0d expected 1", ps); end
      checks++; if (active !== 1'b0 || tone_out !== 1'b0) begin errors++; $display("FAIL basic_stop got active=%0b tone=%0b expected 0 0", active, tone_out); end
      tick();
      checks++; if (period_start !== 1'b0 || active !== 1'b0) begin errors++; $display("FAIL basic_idle got pstart=%0b active=%0b expected 0 0", period_start, active); end
   endtask

   task automatic test_octave();
      int exp, hi, lo, ps;
      en = 1'b1; note_in = 4'd12; octave = 2'd3;
      exp = exp_half(12, 3);
      tick();
      checks++; if (tone_out !== 1'b1) begin errors++; $display("FAIL oct3_rise got %0b expected 1", tone_out); end
      measure_period(exp / 2, 1'b1, 4'd15, 2'd3, exp + 4, hi, lo, ps);
      checks++; if (hi !== exp) begin errors++; $display("FAIL oct3_high got %0d expected %0d", hi, exp); end
      checks++; if (lo !== exp) begin errors++; $display("FAIL oct3_low got %0d expected %0d", lo, exp); end
      checks++; if (active !== 1'b0 || tone_out !== 1'b0) begin errors++; $display("FAIL oct3_stop got active=%0b tone=%0b expected 0 0", active, tone_out); end

      en = 1'b1; note_in = 4'd9; octave = 2'd1;
      exp = exp_half(9, 1);
      tick();
      checks++; if (tone_out !== 1'b1) begin errors++; $display("FAIL oct1_rise got %0b expected 1", tone_out); end
      measure_period(10, 1'b0, 4'd9, 2'd1, exp + 4, hi, lo, ps);
      checks++; if (hi !== exp) begin errors++; $display("FAIL oct1_high got %0d expected %0d", hi, exp); end
      checks++; if (lo !== exp) begin errors++; $display("FAIL oct1_low got %0d expected %0d", lo, exp); end
      checks++; if (ps !== 1) begin errors++; $display("FAIL oct1_pstart_count got %0d expected 1", ps); end
   endtask

   task automatic test_note_change();
      int exp_a, exp_b, hi, lo, ps;
      en = 1'b1; note_in = 4'd9; octave = 2'd2;
      exp_a = exp_half(9, 2);
      exp_b = exp_half(0, 2);
      tick();
      measure_period(exp_a / 2, 1'b1, 4'd0, 2'd2, exp_a + 4, hi, lo, ps);
      checks++; if (hi !== exp_a) begin errors++; $display("FAIL chg_old_high got %0d expected %0d", hi, exp_a); end
      checks++; if (lo !== exp_a) begin errors++; $display("FAIL chg_old_low got %0d expected %0d", lo, exp_a); end
      checks++; if (tone_out !== 1'b1 || period_start !== 1'b1) begin errors++; $display("FAIL chg_no_gap got tone=%0b pstart=%0b expected 1 1", tone_out, period_start); end
      measure_period(100, 1'b0, 4'd0, 2'd2, exp_b + 4, hi, lo, ps);
      checks++; if (hi !== exp_b) begin errors++; $display("FAIL chg_new_high got %0d expected %0d", hi, exp_b); end
      checks++; if (lo !== exp_b) begin errors++; $display("FAIL chg_new_low got %0d expected %0d", lo, exp_b); end
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL chg_stop got %0b expected 0", active); end
   endtask

   task automatic test_idle_silent();
      for (int n = 13; n <= 15; n++) begin
         en = 1'b1; note_in = 4'(n); octave = 2'($urandom_range(0, 3));
         repeat (5) tick();
         checks++; if (active !== 1'b0 || tone_out !== 1'b0 || period_start !== 1'b0) begin
            errors++; $display("FAIL silent_code_%0d got active=%0b tone=%0b pstart=%0b expected 0 0 0", n, active, tone_out, period_start);
         end
      end
      en = 1'b0; note_in = 4'd4; octave = 2'd3;
      repeat (5) tick();
      checks++; if (active !== 1'b0 || tone_out !== 1'b0) begin errors++; $display("FAIL silent_en0 got active=%0b tone=%0b expected 0 0", active, tone_out); end
   endtask

   task automatic test_random_b2b();
      int n_cur, n_nxt, exp, act, hi, lo, ps;
      logic [3:0] sil_note;
      logic       sil_en;
      n_cur = $urandom_range(0, 12);
      en = 1'b1; note_in = 4'(n_cur); octave = 2'd3;
      tick();
      checks++; if (tone_out !== 1'b1 || period_start !== 1'b1) begin errors++; $display("FAIL rnd_rise got tone=%0b pstart=%0b expected 1 1", tone_out, period_start); end
      for (int k = 0; k < 4; k++) begin
         exp = exp_half(n_cur, 3);
         act = $urandom_range(1, exp - 1);
         n_nxt = $urandom_range(0, 12);
         if (k < 3) begin
            measure_period(act, 1'b1, 4'(n_nxt), 2'd3, exp + 4, hi, lo, ps);
         end else begin
            sil_en   = 1'($urandom_range(0, 1));
            sil_note = sil_en ? 4'($urandom_range(13, 15)) : 4'(n_cur);
            measure_period(act, sil_en, sil_note, 2'd3, exp + 4, hi, lo, ps);
         end
         checks++; if (hi !== exp) begin errors++; $display("FAIL rnd_high k=%0d note=%0d got %0d expected %0d", k, n_cur, hi, exp); end
         checks++; if (lo !== exp) begin errors++; $display("FAIL rnd_low k=%0d note=%0d got %0d expected %0d", k, n_cur, lo, exp); end
         checks++; if (ps !== 1) begin errors++; $display("FAIL rnd_pstart_count k=%0d got %0d expected 1", k, ps); end
         if (k < 3) begin
            checks++; if (tone_out !== 1'b1) begin errors++; $display("FAIL rnd_no_gap k=%0d got %0b expected 1", k, tone_out); end
         end else begin
            checks++; if (active !== 1'b0 || tone_out !== 1'b0) begin errors++; $display("FAIL rnd_stop got active=%0b tone=%0b expected 0 0", active, tone_out); end
         end
         n_cur = n_nxt;
      end
   endtask

   task automatic test_reset_mid();
      en = 1'b1; note_in = 4'd9; octave = 2'd0;
      tick();
      repeat (100) tick();
      checks++; if (tone_out !== 1'b1) begin errors++; $display("FAIL rmid_pre_tone got %0b expected 1", tone_out); end
      #3;
      n_rst = 1'b0;
      #1;
      checks++; if (tone_out !== 1'b0) begin errors++; $display("FAIL rmid_async_tone got %0b expected 0", tone_out); end
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL rmid_async_active got %0b expected 0", active); end
      checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL rmid_async_pstart got %0b expected 0", period_start); end
      tick();
      n_rst = 1'b1;
      checks++; if (tone_out !== 1'b0) begin errors++; $display("FAIL rmid_release_tone got %0b expected 0", tone_out); end
      tick();
      checks++; if (tone_out !== 1'b1 || period_start !== 1'b1 || active !== 1'b1) begin
         errors++; $display("FAIL rmid_restart got tone=%0b pstart=%0b active=%0b expected 1 1 1", tone_out, period_start, active);
      end
      tick();
      checks++; if (period_start !== 1'b0 || tone_out !== 1'b1) begin errors++; $display("FAIL rmid_second got pstart=%0b tone=%0b expected 0 1", period_start, tone_out); end
      en = 1'b0;
      #2;
      n_rst = 1'b0;
      #1;
      checks++; if (tone_out !== 1'b0 || active !== 1'b0) begin errors++; $display("FAIL rmid_final got tone=%0b active=%0b expected 0 0", tone_out, active); end
      tick();
      n_rst = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_octave();
      test_note_change();
      test_idle_silent();
      test_random_b2b();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
